// File: rtl/cubic_pkg.sv
// rtl/cubic_pkg.sv - shared constants, formats and state encoding for cubic_seq
//
// Purpose: fixed-point format widths, the two constants of
//          f(x) = 0.85*x^3 + 1, and the FSM state encoding.
// Ports:   none (package)
package cubic_pkg;

    localparam int DATA_W = 10;
    localparam int PROD_W = 20;

    // 0.85 as unsigned fix<10,9>: 0.85*512 = 435.2, truncated
    localparam logic [DATA_W-1:0] CONST_K   = 10'd435;
    // 1.0 as fix<10,6>
    localparam logic [DATA_W-1:0] CONST_ONE = 10'd64;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SQ   = 3'd1,
        CU   = 3'd2,
        CM   = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/fixmul20.sv
// rtl/fixmul20.sv - combinational 20x20 -> 20-bit two's-complement multiplier
//
// Purpose: the single shared multiplier of cubic_seq. Only the low 20 bits of
//          the product are kept (mod 2^20); those bits are identical for
//          signed and unsigned interpretation of the operands.
// Ports:   a  in  20  operand A (already sign/zero extended by caller)
//          b  in  20  operand B (already sign/zero extended by caller)
//          p  out 20  a*b mod 2^20
module fixmul20
    import cubic_pkg::*;
(
    input  logic [PROD_W-1:0] a,
    input  logic [PROD_W-1:0] b,
    output logic [PROD_W-1:0] p
);

    assign p = a * b;

endmodule

// File: rtl/cubic_seq.sv
// rtl/cubic_seq.sv - multi-cycle evaluator of f(x) = 0.85*x^3 + 1
//
// Purpose: computes f(x) with one shared multiplier over three FSM steps
//          (square, cube, scale) between valid/ready handshakes.
// Ports:   clk        in   1   rising-edge clock
//          reset      in   1   synchronous, active-high reset
//          in_valid   in   1   x presented on in_data
//          in_ready   out  1   high only in IDLE
//          in_data    in   10  x, signed fix<10,7>
//          out_valid  out  1   result held on out_data/out_ovf (DONE)
//          out_ready  in   1   consumer accepts result
//          out_data   out  10  f(x), signed fix<10,6>; 0 on overflow
//          out_ovf    out  1   overflow flag for the current result
module cubic_seq
    import cubic_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_ovf
);

    localparam int EXT_W = PROD_W - DATA_W;

    state_t state;
    state_t state_nxt;

    logic [DATA_W-1:0] x_r;
    logic [DATA_W-1:0] sq_r;
    logic [DATA_W-1:0] cu_r;
    logic              ovf_r;

    logic [PROD_W-1:0] op_a;
    logic [PROD_W-1:0] op_b;
    logic [PROD_W-1:0] prod;

    logic              sq_ovf;
    logic              cu_ovf;
    logic [DATA_W-1:0] cm_sum;
    logic              unused_prod_lsbs;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = SQ;
                end
            end
            SQ:   state_nxt = CU;
            CU:   state_nxt = CM;
            CM:   state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand mux: exactly one multiply per compute state
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (state)
            SQ: begin
                op_a = {{EXT_W{x_r[DATA_W-1]}}, x_r};
                op_b = {{EXT_W{x_r[DATA_W-1]}}, x_r};
            end
            CU: begin
                // square is non-negative, so zero extension
                op_a = {{EXT_W{1'b0}}, sq_r};
                op_b = {{EXT_W{x_r[DATA_W-1]}}, x_r};
            end
            CM: begin
                op_a = {{EXT_W{1'b0}}, CONST_K};
                op_b = {{EXT_W{cu_r[DATA_W-1]}}, cu_r};
            end
            default: begin
                op_a = '0;
                op_b = '0;
            end
        endcase
    end

    fixmul20 u_mul (
        .a (op_a),
        .b (op_b),
        .p (prod)
    );

    // The square is never negative: any upper bit means it does not fit.
    assign sq_ovf = (prod[19:17] != 3'b000);
    // The cube is signed: upper bits must be a pure sign extension.
    assign cu_ovf = (prod[19:17] != 3'b000) && (prod[19:17] != 3'b111);
    // Wraparound add, no saturation
    assign cm_sum = prod[18:9] + CONST_ONE;

    assign unused_prod_lsbs = ^prod[6:0];

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            x_r      <= '0;
            sq_r     <= '0;
            cu_r     <= '0;
            ovf_r    <= 1'b0;
            out_data <= '0;
            out_ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_r <= in_data;
                    end
                end
                SQ: begin
                    sq_r  <= prod[16:7];
                    ovf_r <= sq_ovf;
                end
                CU: begin
                    cu_r  <= prod[17:8];
                    ovf_r <= ovf_r | cu_ovf;
                end
                CM: begin
                    out_data <= ovf_r ? '0 : cm_sum;
                    out_ovf  <= ovf_r;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
